// File: rtl/gf2m_pkg.sv
// Shared GF(2^M) constants for the sect193 trinomial f(x)=x^M+x^K+1.
// Field sizes, fold geometry, reduction FSM states and the f(x) bit pattern.
package gf2m_pkg;

  localparam int M     = 193;
  localparam int K     = 15;
  localparam int CHUNK = 16;
  localparam int NFOLD = (M - 1) / CHUNK;
  localparam int PW    = 2 * M - 1;
  localparam int CW    = (NFOLD > 1) ? $clog2(NFOLD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FOLD,
    DONE
  } state_t;

  // f(x) = x^M + x^K + 1, bit i = coefficient of x^i
  localparam logic [M:0] F_POLY =
    {1'b1, {(M-K-1){1'b0}}, 1'b1, {(K-1){1'b0}}, 1'b1};

  // x^M mod f(x) = x^K + 1
  localparam logic [M-1:0] F_LOW = F_POLY[M-1:0];

endpackage

// File: rtl/gf2m_fold_chunk.sv
// One reduction step: folds CHUNK bits of acc, chosen by cnt, into lower bits.
// Ports: acc_i working product, cnt_i fold index, acc_o next working product.
module gf2m_fold_chunk
  import gf2m_pkg::*;
(
  input  logic [PW-1:0] acc_i,
  input  logic [CW-1:0] cnt_i,
  output logic [PW-1:0] acc_o
);

  logic [CHUNK-1:0] w;
  int               t;

  // x^(t-j) = x^(t-j-M+K) + x^(t-j-M) for every bit j of the window
  always_comb begin
    t     = (M - 1) + (int'(cnt_i) + 1) * CHUNK;
    w     = acc_i[t -: CHUNK];
    acc_o = acc_i;
    acc_o[t -: CHUNK] = '0;
    acc_o[t-M+K -: CHUNK] = acc_o[t-M+K -: CHUNK] ^ w;
    acc_o[t-M -: CHUNK]   = acc_o[t-M -: CHUNK] ^ w;
  end

endmodule

// File: rtl/gf2m_reduce_seq.sv
// Sequential reduction of a (2M-1)-bit carry-less product modulo f(x).
// Ports: clk, rst_n, in_valid/in_ready/in_prod, out_valid/out_ready/out_rem, busy.
module gf2m_reduce_seq
  import gf2m_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_rem,
  output logic          busy
);

  state_t        state_q;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_d;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [M-1:0]  out_rem_q;

  gf2m_fold_chunk u_fold (
    .acc_i (acc_q),
    .cnt_i (cnt_q),
    .acc_o (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_rem_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= in_prod;
            cnt_q      <= CW'(NFOLD - 1);
            state_q    <= FOLD;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        FOLD: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            // capture the result so out_rem stays put through DONE
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_rem_q   <= acc_d[M-1:0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_rem   = out_rem_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Self-checking bench for gf2m_reduce_seq against a bit-serial reference.
// Directed corner products, backpressure, back-to-back, reset abort, random.
module tb_gf2m_reduce_seq;
  import gf2m_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_rem;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [M-1:0] expq[$];
  int           out_cycs[$];
  int           acc_cyc;
  logic         prev_ov;
  logic [M-1:0] held;

  gf2m_reduce_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rem   (out_rem),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // x^i = x^(i-M+K) + x^(i-M), applied one bit at a time from the top
  function automatic logic [M-1:0] ref_reduce(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    for (int i = PW - 1; i >= M; i--) begin
      if (r[i]) begin
        r[i]       = 1'b0;
        r[i-M+K]   = ~r[i-M+K];
        r[i-M]     = ~r[i-M];
      end
    end
    return r[M-1:0];
  endfunction

  function automatic logic [PW-1:0] rnd_prod();
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < 13; i++) r = {r[PW-33:0], 32'($urandom)};
    if ($urandom_range(0, 7) == 0) r[PW-1:M] = '0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  // compare process: model queue of accepted products, checked every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_ov = 1'b0;
    end else begin
      chk1("busy_model", busy, expq.size() != 0);
      chk1("in_ready_model", in_ready, expq.size() == 0);
      if (in_valid && in_ready) begin
        expq.push_back(ref_reduce(in_prod));
        acc_cyc = cyc;
      end
      if (out_valid) begin
        if (!prev_ov) begin
          chk("latency", PW'(cyc - acc_cyc), PW'(13));
          held = out_rem;
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result got=%h want=none", out_rem);
          end else begin
            chk("out_rem", PW'(out_rem), PW'(expq[0]));
          end
        end else begin
          chk("out_rem_stable", PW'(out_rem), PW'(held));
        end
        if (out_ready) begin
          if (expq.size() != 0) void'(expq.pop_front());
          out_cycs.push_back(cyc);
        end
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [PW-1:0] p, input bit hold);
    int n;
    n = 0;
    in_prod  = p;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk1("send_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 100) begin
        chk1("out_timeout", 1'b1, 1'b0);
        break;
      end
    end
  endtask

  task automatic run_one(input string nm, input logic [PW-1:0] p,
                         input logic [M-1:0] exp);
    out_ready = 1'b1;
    send(p, 1'b0);
    wait_out();
    chk(nm, PW'(out_rem), PW'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p;
    logic [M-1:0]  e;
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    bit            rdone;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_prod   = '0;
    #3 rst_n  = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_rem", PW'(out_rem), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // pin the reference model itself
    p = '0; p[193] = 1'b1;
    chk("model_x193", PW'(ref_reduce(p)), PW'(193'h8001));
    e = '0; e[191] = 1'b1; e[28] = 1'b1; e[13] = 1'b1;
    p = '0; p[384] = 1'b1;
    chk("model_x384", PW'(ref_reduce(p)), PW'(e));
    p = '0;
    chk("model_zero", PW'(ref_reduce(p)), '0);
    p = '0; p[192] = 1'b1; p[0] = 1'b1;
    chk("model_lowdeg", PW'(ref_reduce(p)), p);

    // directed corner products
    p = '0; p[193] = 1'b1;
    run_one("x193", p, 193'h8001);
    p = '0; p[384] = 1'b1;
    run_one("x384", p, e);
    p = '0;
    run_one("zero", p, '0);
    p = '0; p[192] = 1'b1; p[0] = 1'b1;
    run_one("x192p1", p, p[M-1:0]);

    // backpressure with a second product waiting
    pa = rnd_prod();
    pb = rnd_prod();
    out_ready = 1'b0;
    send(pa, 1'b0);
    wait_out();
    @(posedge clk);
    #1;
    in_prod  = pb;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk1("bp_release_ready", in_ready, 1'b1);
    chk1("bp_release_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("bp_second_accepted", busy, 1'b1);
    in_valid = 1'b0;
    wait_out();
    chk("bp_second", PW'(out_rem), PW'(ref_reduce(pb)));
    @(posedge clk);
    #1;

    // back-to-back with both sides always willing
    out_cycs.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(rnd_prod(), 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && out_cycs.size() < 4; i++) @(posedge clk);
    #1;
    chk("b2b_count", PW'(out_cycs.size()), PW'(4));
    for (int i = 1; i < 4 && i < out_cycs.size(); i++)
      chk("b2b_spacing", PW'(out_cycs[i] - out_cycs[i-1]), PW'(14));

    // reset during fold cycle 5 aborts the result
    send(rnd_prod(), 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    p = '0; p[384] = 1'b1;
    run_one("after_abort", p, e);

    // random products with random backpressure and gaps
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send(rnd_prod(), 1'b0);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", PW'(expq.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
